// File: rtl/config_pkg.sv
// Shared types and constants for the fabric configuration loader.
// Holds default geometry, FSM state encodings and the configuration word map.
package config_pkg;

    localparam int NUM_WORDS_DEF = 33;
    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 6;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_LOAD  = S_LOAD,
        ST_CHECK = S_CHECK,
        ST_DONE  = S_DONE,
        ST_ERR   = S_ERR
    } state_e;

    // Word map of one fabric image: 16 switch-box words, 16 LUT words, one control word.
    localparam int WIDX_SB_FIRST  = 0;
    localparam int WIDX_SB_LAST   = 15;
    localparam int WIDX_LUT_FIRST = 16;
    localparam int WIDX_LUT_LAST  = 31;
    localparam int WIDX_CTRL      = 32;

endpackage

// File: rtl/cfg_checksum.sv
// Running modulo-2**DATA_W sum of the configuration words of one image.
// Latency: sum reflects a word one clock after add_en.
// Backpressure: none; adds whenever add_en is high.
module cfg_checksum
    import config_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              add_en,
    input  logic [DATA_W-1:0] add_data,
    output logic [DATA_W-1:0] sum
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + add_data;
        end
    end

endmodule

// File: rtl/config_loader.sv
// Streams NUM_WORDS configuration words into fabric storage, then releases the fabric.
// Latency: one clock from word acceptance to wr_en; done/fabric_en rise the cycle after the last write.
// Backpressure: valid/ready; stalls indefinitely on cfg_valid low. Checksum word under CFG_CHECKSUM_EN.
module config_loader
    import config_pkg::*;
#(
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              fabric_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // One extra bit so the counter can reach NUM_WORDS == 2**ADDR_W without wrapping.
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             load_word;
    logic             last_word;
    logic             start_ok;

    assign cfg_ready = (state == ST_LOAD) || (state == ST_CHECK);
    assign accept    = cfg_valid && cfg_ready;
    assign load_word = accept && (state == ST_LOAD);
    assign last_word = load_word && (cnt == LAST_IDX);
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

`ifdef CFG_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic              sum_ok;

    cfg_checksum #(
        .DATA_W (DATA_W)
    ) u_checksum (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (start_ok),
        .add_en   (load_word),
        .add_data (cfg_data),
        .sum      (sum)
    );

    assign sum_ok = (cfg_data == sum);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
`ifdef CFG_CHECKSUM_EN
                if (last_word) state_nxt = ST_CHECK;
`else
                if (last_word) state_nxt = ST_DONE;
`endif
            end
            ST_CHECK: begin
`ifdef CFG_CHECKSUM_EN
                if (accept) state_nxt = sum_ok ? ST_DONE : ST_ERR;
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state <= state_nxt;
            wr_en <= load_word;
            if (start_ok) begin
                cnt <= '0;
            end else if (load_word) begin
                cnt <= cnt + 1'b1;
            end
            if (load_word) begin
                wr_addr <= cnt[ADDR_W-1:0];
                wr_data <= cfg_data;
            end
        end
    end

    // DONE is entered on the same edge as the final write; hold the release off until that write retires.
    assign busy      = (state == ST_LOAD) || (state == ST_CHECK);
    assign done      = (state == ST_DONE) && !wr_en;
    assign fabric_en = (state == ST_DONE) && !wr_en;
    assign error     = (state == ST_ERR);

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader; checksum cases run when CFG_CHECKSUM_EN is defined.
module tb_config_loader;
    import config_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        cfg_valid;
    logic [31:0] cfg_data;
    logic        cfg_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        fabric_en;
    logic        busy;
    logic        done;
    logic        error;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t wq[$];
    int  checks      = 0;
    int  errors      = 0;
    int  busy_watch  = 0;
    int  busy_drops  = 0;
    int  overlaps    = 0;
    int  err_seen    = 0;

    config_loader dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .fabric_en (fabric_en),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (wr_en) wq.push_back({wr_addr, wr_data});
        if (busy_watch != 0 && !busy) busy_drops++;
        if (wr_en && (done || fabric_en)) overlaps++;
        if (error) err_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input int gap);
        int n;
        n = 0;
        repeat (gap) begin
            cfg_valid = 1'b0;
            @(negedge clock);
        end
        cfg_valid = 1'b1;
        cfg_data  = d;
        while (!cfg_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("ready_wait", cfg_ready, 1'b1);
        @(negedge clock);
        cfg_valid = 1'b0;
    endtask

    task automatic close_image(input string tag, input logic [31:0] csum);
`ifdef CFG_CHECKSUM_EN
        check({tag, "_check_busy"}, busy, 1'b1);
        check({tag, "_last_wr"}, wr_en, 1'b1);
        send_word(csum, 0);
`else
        cfg_data = csum;
        check({tag, "_last_wr"}, wr_en, 1'b1);
        check({tag, "_done_not_with_wr"}, done, 1'b0);
        check({tag, "_fab_not_with_wr"}, fabric_en, 1'b0);
        @(negedge clock);
`endif
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_fabric_en"}, fabric_en, 1'b1);
        check({tag, "_busy_off"}, busy, 1'b0);
        check({tag, "_wr_off"}, wr_en, 1'b0);
    endtask

    task automatic check_seq(input string tag, input int n, input logic [31:0] base);
        check({tag, "_count"}, wq.size(), n);
        for (int i = 0; i < wq.size() && i < n; i++) begin
            check({tag, "_addr"}, wq[i].a, i);
            check({tag, "_data"}, wq[i].d, base + i);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        repeat (3) @(negedge clock);
        check("reset_outputs", {cfg_ready, wr_en, wr_addr, wr_data, fabric_en, busy, done, error}, '0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_busy", busy, 1'b0);
        check("idle_ready", cfg_ready, 1'b0);

        // Back-to-back image, data equals address.
        pulse_start();
        check("a_busy", busy, 1'b1);
        check("a_ready", cfg_ready, 1'b1);
        wq.delete();
        for (int i = 0; i < 32; i++) send_word(i, 0);
        send_word(32, 0);
        close_image("a", 32'h210);
        check_seq("a", 33, 0);
        check("a_last_is_ctrl", wq[32].a, WIDX_CTRL);

        // Restart from DONE with a throttled source.
        pulse_start();
        check("b_fabric_drop", fabric_en, 1'b0);
        check("b_done_drop", done, 1'b0);
        check("b_busy", busy, 1'b1);
        wq.delete();
        busy_watch = 1;
        for (int i = 0; i < 32; i++) send_word(i, 1);
        busy_watch = 0;
        send_word(32, 1);
        close_image("b", 32'h210);
        check_seq("b", 33, 0);
        check("b_busy_held", busy_drops, 0);

        // Start during LOAD must not disturb the counter.
        pulse_start();
        wq.delete();
        for (int i = 0; i < 5; i++) send_word(i, 0);
        pulse_start();
        check("c_still_busy", busy, 1'b1);
        for (int i = 5; i < 33; i++) send_word(i, 0);
        close_image("c", 32'h210);
        check_seq("c", 33, 0);

        // Reset mid-image abandons it.
        pulse_start();
        for (int i = 0; i < 10; i++) send_word(32'h100 + i, 0);
        reset_n   = 1'b0;
        #1;
        check("d_reset_async", {cfg_ready, wr_en, wr_addr, wr_data, fabric_en, busy, done, error}, '0);
        start     = 1'b1;
        cfg_valid = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("d_reset_held", {cfg_ready, wr_en, wr_addr, wr_data, fabric_en, busy, done, error}, '0);
        start     = 1'b0;
        cfg_valid = 1'b0;
        reset_n   = 1'b1;
        @(negedge clock);
        check("d_idle_after_reset", busy, 1'b0);
        pulse_start();
        wq.delete();
        for (int i = 0; i < 33; i++) send_word(32'h1000 + i, 0);
        close_image("d", 32'h21210);
        check_seq("d", 33, 32'h1000);

`ifdef CFG_CHECKSUM_EN
        pulse_start();
        for (int i = 0; i < 33; i++) send_word(32'h1, 0);
        send_word(32'h21, 0);
        check("e_done", done, 1'b1);
        check("e_error", error, 1'b0);
        check("e_fabric", fabric_en, 1'b1);

        pulse_start();
        wq.delete();
        for (int i = 0; i < 33; i++) send_word(32'h1, 0);
        send_word(32'h22, 0);
        check("f_error", error, 1'b1);
        check("f_fabric", fabric_en, 1'b0);
        check("f_done", done, 1'b0);
        check("f_busy", busy, 1'b0);
        @(negedge clock);
        check("f_no_csum_write", wq.size(), 33);
`else
        check("no_error_state", err_seen, 0);
`endif
        check("no_wr_done_overlap", overlaps, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 33, the number of configuration words per fabric image.
REQ-002 SHALL have parameter DATA_W, default 32, the configuration word width.
REQ-003 SHALL have parameter ADDR_W, default 6, the write-address width; NUM_WORDS SHALL be no greater than 2**ADDR_W.
REQ-004 SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle pulse that begins an image load.
REQ-007 SHALL have port cfg_valid, input, 1 bit: the source presents a word.
REQ-008 SHALL have port cfg_data, input, DATA_W bits: the configuration word.
REQ-009 SHALL have port cfg_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-010 SHALL have port wr_en, output, 1 bit: write strobe to the fabric configuration storage.
REQ-011 SHALL have port wr_addr, output, ADDR_W bits: word index, 0..NUM_WORDS-1.
REQ-012 SHALL have port wr_data, output, DATA_W bits: word to write.
REQ-013 SHALL have port fabric_en, output, 1 bit: releases the fabric for operation.
REQ-014 SHALL have ports busy, done and error, output, 1 bit each: status flags.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, CHECK, DONE and ERR.
REQ-016 SHALL move from IDLE, DONE or ERR to LOAD on start; on that transition the word counter SHALL clear and fabric_en SHALL deassert.
REQ-017 SHALL ignore start while in LOAD or CHECK.
REQ-018 SHALL assert cfg_ready only in LOAD, or in CHECK while the checksum word is still pending.
REQ-019 SHALL count a word as accepted only when cfg_valid and cfg_ready are both high; an accepted word SHALL NOT be dropped or duplicated.
REQ-020 SHALL assert wr_en for one cycle, one clock after acceptance, with wr_addr equal to the counter value at acceptance and wr_data equal to the accepted word.
REQ-021 SHALL hold wr_addr and wr_data stable while wr_en is low.
REQ-022 SHALL increment the counter per accepted word and SHALL NOT wrap it.
REQ-023 SHALL leave LOAD after accepting word NUM_WORDS-1: to CHECK when CFG_CHECKSUM_EN is defined, otherwise to DONE.
REQ-024 SHALL stall without timeout when cfg_valid stays low; busy SHALL remain high.
REQ-025 SHALL hold busy high exactly in LOAD and CHECK.
REQ-026 SHALL hold done high only in DONE and error high only in ERR.
REQ-027 SHALL hold fabric_en high only in DONE.
REQ-028 SHALL make done and fabric_en rise on the cycle after the final wr_en pulse, never together with it.

Reset
REQ-029 SHALL, while reset_n is low, force state IDLE, counter 0, cfg_ready 0, wr_en 0, wr_addr 0, wr_data 0, fabric_en 0, busy 0, done 0, error 0 and checksum accumulator 0.
REQ-030 SHALL, on reset during LOAD, abandon the partial image; the next load SHALL begin at address 0.

Configuration
REQ-031 SHALL, when CFG_CHECKSUM_EN is defined, accumulate the modulo-2**DATA_W sum of all NUM_WORDS words.
REQ-032 SHALL, when CFG_CHECKSUM_EN is defined, accept one further word in CHECK and go to DONE if it equals the sum, or to ERR otherwise, with no write for that word.
REQ-033 SHALL, when CFG_CHECKSUM_EN is not defined, omit the CHECK state and the accumulator; ERR SHALL then be unreachable.

Structure
REQ-034 SHALL take the state enum, the default NUM_WORDS, DATA_W and ADDR_W, and named word-index constants (switch-box and LUT slots, index 0..32) from the shared package config_pkg.
REQ-035 SHALL place the accumulator in one sub-module, cfg_checksum, instantiated only under CFG_CHECKSUM_EN.

Verification
REQ-036 SHALL cover: start, then 33 back-to-back words 0x00000000..0x00000020 -> 33 wr_en pulses, addresses 0..32 with data equal to address, done and fabric_en high one cycle after the last pulse.
REQ-037 SHALL cover: cfg_valid toggled every other cycle -> identical write sequence, busy held high throughout, no duplicate addresses.
REQ-038 SHALL cover: reset_n pulsed low after 10 words, then a new start -> first write at address 0 and all outputs at reset values during reset.
REQ-039 SHALL cover, with CFG_CHECKSUM_EN: 33 words of 0x00000001 then 0x00000021 -> done=1; the same words then 0x00000022 -> error=1, fabric_en=0.
REQ-040 SHALL cover: start pulsed mid-LOAD -> ignored with the counter unchanged; start in DONE -> fabric_en drops and the load restarts at address 0.
